// File: rtl/mips_bus_fetch_stub.sv
// Stand-in bus master for the MIPS CPU: fetches words from RESET_VECTOR, sums them
// into register_v0 until a halt word or word limit, optionally writes the sum back.
module mips_bus_fetch_stub #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned MAX_WORDS    = 16,
  parameter logic [31:0] HALT_WORD    = 32'h00000008,
  parameter bit          WRITEBACK    = 1'b1,
  parameter logic [31:0] RESULT_ADDR  = 32'h00001000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam int unsigned   CW       = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic          active_q, active_d;
  logic [31:0]   v0_q, v0_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [31:0]   writedata_q, writedata_d;
  logic [3:0]    be_q, be_d;

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    v0_d        = v0_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;
    be_d        = be_q;
    unique case (state_q)
      IDLE: begin
        state_d   = FETCH;
        active_d  = 1'b1;
        read_d    = 1'b1;
        be_d      = '1;
        address_d = ptr_q;
      end
      FETCH: begin
        if (!waitrequest) begin
          cnt_d = cnt_q + CW'(1);
          if (readdata != HALT_WORD) v0_d = v0_q + readdata;
          if (readdata == HALT_WORD || cnt_q == LAST_CNT) begin
            read_d = 1'b0;
            if (WRITEBACK) begin
              state_d     = WRITE;
              write_d     = 1'b1;
              address_d   = RESULT_ADDR;
              // Write the sum including the word accepted in this same cycle
              writedata_d = v0_d;
            end else begin
              state_d  = DONE;
              active_d = 1'b0;
              be_d     = '0;
            end
          end else begin
            ptr_d     = ptr_q + 32'd4;
            address_d = ptr_q + 32'd4;
          end
        end
      end
      WRITE: begin
        if (!waitrequest) begin
          state_d  = DONE;
          write_d  = 1'b0;
          active_d = 1'b0;
          be_d     = '0;
        end
      end
      DONE: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      active_q    <= 1'b0;
      v0_q        <= '0;
      ptr_q       <= RESET_VECTOR;
      cnt_q       <= '0;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      writedata_q <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      v0_q        <= v0_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
      be_q        <= be_d;
    end
  end

  assign active      = active_q;
  assign register_v0 = v0_q;
  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = writedata_q;
  assign byteenable  = be_q;

endmodule
